// File: rtl/ps2_host_tx_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, frame length and
// common mouse command bytes.
package ps2_host_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RTS,
    START,
    DATA,
    STOP
  } ps2_tx_state_e;

  localparam int unsigned PS2_FRAME_BITS    = 11;
  localparam logic [7:0]  PS2_CMD_EN_REPORT = 8'hF4;

  function automatic logic odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_clk_filter.sv
// PS/2 clock glitch filter with a one-cycle falling-edge pulse; the same
// block feeds the receive path.
module ps2_clk_filter #(
  parameter int unsigned FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2c_i,
  output logic fall_edge_o
);

  logic [FILTER_LEN-1:0] filter_q, filter_d;
  logic                  fclk_q, fclk_d;

  always_comb begin
    filter_d = {ps2c_i, filter_q[FILTER_LEN-1:1]};
    fclk_d   = fclk_q;
    if (filter_d == '1)
      fclk_d = 1'b1;
    else if (filter_d == '0)
      fclk_d = 1'b0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      filter_q <= '1;
      fclk_q   <= 1'b1;
    end else begin
      filter_q <= filter_d;
      fclk_q   <= fclk_d;
    end
  end

  assign fall_edge_o = fclk_q & ~fclk_d;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: request-to-send, 11-bit frame clocked by
// the device, ACK/NACK check and inter-edge timeout. Lines are open-drain.
module ps2_host_tx
  import ps2_host_tx_pkg::*;
#(
  parameter int unsigned RTS_CYCLES     = 6000,
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_ps2,
  input  logic [7:0] din,
  inout  wire        ps2c,
  inout  wire        ps2d,
  output logic       tx_idle,
  output logic       tx_done_tick,
  output logic       tx_err_tick
);

  localparam int unsigned CNT_MAX = (RTS_CYCLES > TIMEOUT_CYCLES) ? RTS_CYCLES : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  ps2_tx_state_e    state_q;
  logic [8:0]       shift_q;
  logic [3:0]       n_q;
  logic [CNT_W-1:0] cnt_q;
  logic             c_low_q, d_low_q;
  logic             idle_q, done_q, err_q;
  logic [1:0]       d_sync_q;
  logic             fall_edge;

  ps2_clk_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filter (
    .clk_i      (clk),
    .rst_i      (reset),
    .ps2c_i     (ps2c),
    .fall_edge_o(fall_edge)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      d_sync_q <= '1;
    else
      d_sync_q <= {d_sync_q[0], ps2d};
  end

  // Line drives are registered, so each branch loads the value the next
  // state requires; in DATA that is the bit that will sit in shift_q[0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      n_q     <= '0;
      cnt_q   <= '0;
      c_low_q <= 1'b0;
      d_low_q <= 1'b0;
      idle_q  <= 1'b1;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          c_low_q <= 1'b0;
          d_low_q <= 1'b0;
          idle_q  <= 1'b1;
          if (wr_ps2) begin
            shift_q <= {odd_parity(din), din};
            n_q     <= '0;
            cnt_q   <= '0;
            c_low_q <= 1'b1;
            idle_q  <= 1'b0;
            state_q <= RTS;
          end
        end
        RTS: begin
          if (cnt_q == CNT_W'(RTS_CYCLES - 1)) begin
            cnt_q   <= '0;
            n_q     <= 4'(PS2_FRAME_BITS - 3);
            c_low_q <= 1'b0;
            d_low_q <= 1'b1;
            state_q <= START;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        START, DATA, STOP: begin
          if (fall_edge) begin
            cnt_q <= '0;
            case (state_q)
              START: begin
                d_low_q <= ~shift_q[0];
                state_q <= DATA;
              end
              DATA: begin
                if (n_q == 4'd0) begin
                  d_low_q <= 1'b0;
                  state_q <= STOP;
                end else begin
                  shift_q <= {1'b0, shift_q[8:1]};
                  n_q     <= n_q - 4'd1;
                  d_low_q <= ~shift_q[1];
                end
              end
              default: begin
                if (d_sync_q[1] == 1'b0)
                  done_q <= 1'b1;
                else
                  err_q <= 1'b1;
                idle_q  <= 1'b1;
                state_q <= IDLE;
              end
            endcase
          end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            err_q   <= 1'b1;
            c_low_q <= 1'b0;
            d_low_q <= 1'b0;
            idle_q  <= 1'b1;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ps2c         = c_low_q ? 1'b0 : 1'bz;
  assign ps2d         = d_low_q ? 1'b0 : 1'bz;
  assign tx_idle      = idle_q;
  assign tx_done_tick = done_q;
  assign tx_err_tick  = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the
// DUT, and results are compared with a table plus a parity/ACK model.
module tb_ps2_host_tx;
  import ps2_host_tx_pkg::*;

  localparam int unsigned RTS     = 6000;
  localparam int unsigned TIMEOUT = 2000;
  localparam int          H       = 100;   // device half-period in clk cycles

  localparam int M_NORMAL  = 0;
  localparam int M_GLITCH  = 1;
  localparam int M_TIMEOUT = 2;
  localparam int M_RESET   = 3;

  typedef struct {
    logic [7:0] din;
    bit         ack;
    int         mode;
    bit         exp_par;
    bit         exp_done;
    bit         exp_err;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_ps2;
  logic [7:0] din;
  wire        ps2c, ps2d;
  logic       tx_idle, tx_done_tick, tx_err_tick;
  logic       dev_c_low, dev_d_low;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;

  always #10 clk = ~clk;

  pullup (ps2c);
  pullup (ps2d);
  assign ps2c = dev_c_low ? 1'b0 : 1'bz;
  assign ps2d = dev_d_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .RTS_CYCLES    (RTS),
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (rst),
    .wr_ps2      (wr_ps2),
    .din         (din),
    .ps2c        (ps2c),
    .ps2d        (ps2d),
    .tx_idle     (tx_idle),
    .tx_done_tick(tx_done_tick),
    .tx_err_tick (tx_err_tick)
  );

  always @(negedge clk) begin
    if (tx_done_tick === 1'b1) done_cnt++;
    if (tx_err_tick === 1'b1) err_cnt++;
    if (tx_done_tick === 1'b1 && tx_err_tick === 1'b1) both_cnt++;
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Odd parity: the parity bit is 1 exactly when the byte has an even number of ones.
  function automatic bit model_par(input logic [7:0] b);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(b[i]);
    return (ones % 2) == 0;
  endfunction

  task automatic do_frame(input vec_t v);
    int         cyc;
    int         d0, e0;
    logic [9:0] got;
    bit         aborted;
    got = '0;
    aborted = 1'b0;
    @(negedge clk);
    check("idle_before", tx_idle, 1);
    wr_ps2 = 1'b1;
    din    = v.din;
    @(negedge clk);
    wr_ps2 = 1'b0;
    din    = 8'($urandom);
    d0 = done_cnt;
    e0 = err_cnt;
    check("busy_idle", tx_idle, 0);

    cyc = 0;
    while (ps2c === 1'b0 && cyc < 3 * RTS) begin
      cyc++;
      @(negedge clk);
    end
    check("rts_len", cyc, RTS);
    check("start_bit", ps2d, 0);

    if (v.mode == M_TIMEOUT) begin
      cyc = 0;
      while (tx_err_tick !== 1'b1 && cyc < 3 * TIMEOUT) begin
        @(negedge clk);
        cyc++;
      end
      check("timeout_len", cyc, TIMEOUT);
      @(negedge clk);
      check("to_ps2c_rel", ps2c, 1);
      check("to_ps2d_rel", ps2d, 1);
    end else begin
      wait_cyc(50);
      for (int k = 1; k <= 11; k++) begin
        if (k == 11 && v.ack) dev_d_low = 1'b1;
        dev_c_low = 1'b1;
        if (v.mode == M_GLITCH && k == 6) begin
          wait_cyc(20);
          wr_ps2 = 1'b1;
          din    = 8'hFF;
          @(negedge clk);
          wr_ps2 = 1'b0;
          wait_cyc(H - 21);
        end else begin
          wait_cyc(H);
        end
        dev_c_low = 1'b0;
        if (k <= 10) got[k-1] = ps2d;
        if (v.mode == M_RESET && k == 5) begin
          check("pre_reset_d", ps2d, 0);
          rst = 1'b1;
          #1;
          check("reset_rel_c", ps2c, 1);
          check("reset_rel_d", ps2d, 1);
          check("reset_idle", tx_idle, 1);
          @(negedge clk);
          rst = 1'b0;
          aborted = 1'b1;
          break;
        end
        if (v.mode == M_GLITCH && k == 4) begin
          wait_cyc(40);
          dev_c_low = 1'b1;
          wait_cyc(3);
          dev_c_low = 1'b0;
          wait_cyc(H - 43);
        end else begin
          wait_cyc(H);
        end
      end
      dev_d_low = 1'b0;
      if (!aborted) check("frame_bits", got, {1'b1, v.exp_par, v.din});
    end

    wait_cyc(20);
    check("done_ticks", done_cnt - d0, int'(v.exp_done));
    check("err_ticks", err_cnt - e0, int'(v.exp_err));
    check("idle_after", tx_idle, 1);
    check("ps2c_released", ps2c, 1);
    check("ps2d_released", ps2d, 1);
    if (v.mode == M_GLITCH) begin
      wait_cyc(200);
      check("no_stray_rts", ps2c, 1);
    end
  endtask

  vec_t tbl[8];

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{din: PS2_CMD_EN_REPORT, ack: 1'b1, mode: M_NORMAL, exp_par: 1'b0, exp_done: 1'b1, exp_err: 1'b0};
    tbl[1] = '{din: 8'h00, ack: 1'b1, mode: M_NORMAL,  exp_par: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    tbl[2] = '{din: 8'hA5, ack: 1'b0, mode: M_NORMAL,  exp_par: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
    tbl[3] = '{din: 8'h3C, ack: 1'b1, mode: M_GLITCH,  exp_par: 1'b1, exp_done: 1'b1, exp_err: 1'b0};
    tbl[4] = '{din: 8'h5A, ack: 1'b1, mode: M_TIMEOUT, exp_par: 1'b1, exp_done: 1'b0, exp_err: 1'b1};
    tbl[5] = '{din: 8'h00, ack: 1'b1, mode: M_RESET,   exp_par: 1'b1, exp_done: 1'b0, exp_err: 1'b0};
    for (int i = 6; i < 8; i++) begin
      tbl[i].din      = 8'($urandom);
      tbl[i].ack      = 1'($urandom_range(0, 1));
      tbl[i].mode     = M_NORMAL;
      tbl[i].exp_par  = model_par(tbl[i].din);
      tbl[i].exp_done = tbl[i].ack;
      tbl[i].exp_err  = !tbl[i].ack;
    end

    rst       = 1'b1;
    wr_ps2    = 1'b0;
    din       = '0;
    dev_c_low = 1'b0;
    dev_d_low = 1'b0;
    wait_cyc(2);
    check("rst_idle", tx_idle, 1);
    check("rst_done", tx_done_tick, 0);
    check("rst_err", tx_err_tick, 0);
    check("rst_ps2c", ps2c, 1);
    check("rst_ps2d", ps2d, 1);
    rst = 1'b0;
    wait_cyc(20);

    for (int i = 0; i < 8; i++) begin
      do_frame(tbl[i]);
      wait_cyc(10);
    end
    check("tick_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
